// File: rtl/cv32e40p_fetch_aligner.sv
// Instruction aligner: turns word-aligned fetch words into 16/32-bit instructions
// with PC tracking, halfword residue for straddling instructions and branch redirect.
module cv32e40p_fetch_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic        instr_is_compressed_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  typedef enum logic [1:0] {
    ALIGNED    = 2'd0,
    MISALIGNED = 2'd1,
    BRANCH_MIS = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] hw_q, hw_d;
  logic [31:0] pc_q, pc_d;

  logic        instr_valid;
  logic        fetch_ready;
  logic [31:0] instr;
  logic        fetch_hs;

  // Low address bits that never reach the datapath (PCs are halfword/word aligned).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{branch_addr_i[0], boot_addr_i[1:0]};

  function automatic logic is_full_len(input logic [1:0] opc);
    return opc == 2'b11;
  endfunction

  assign fetch_hs = fetch_valid_i & fetch_ready;

  always_comb begin
    state_d     = state_q;
    hw_d        = hw_q;
    pc_d        = pc_q;
    instr       = 32'h0;
    instr_valid = 1'b0;
    fetch_ready = 1'b0;

    unique case (state_q)
      ALIGNED: begin
        instr_valid = fetch_valid_i;
        fetch_ready = id_ready_i;
        if (is_full_len(fetch_rdata_i[1:0])) begin
          instr = fetch_rdata_i;
          if (fetch_valid_i && id_ready_i) begin
            pc_d = pc_q + 32'd4;
          end
        end else begin
          instr = {16'h0, fetch_rdata_i[15:0]};
          if (fetch_valid_i && id_ready_i) begin
            hw_d    = fetch_rdata_i[31:16];
            pc_d    = pc_q + 32'd2;
            state_d = MISALIGNED;
          end
        end
      end

      MISALIGNED: begin
        if (!is_full_len(hw_q[1:0])) begin
          // Residue is a whole compressed instruction; the fetch word waits.
          instr       = {16'h0, hw_q};
          instr_valid = 1'b1;
          fetch_ready = 1'b0;
          if (id_ready_i) begin
            pc_d    = pc_q + 32'd2;
            state_d = ALIGNED;
          end
        end else begin
          instr       = {fetch_rdata_i[15:0], hw_q};
          instr_valid = fetch_valid_i;
          fetch_ready = id_ready_i;
          if (fetch_valid_i && id_ready_i) begin
            hw_d = fetch_rdata_i[31:16];
            pc_d = pc_q + 32'd4;
          end
        end
      end

      BRANCH_MIS: begin
        // Lower halfword precedes the target and is dropped.
        fetch_ready = 1'b1;
        if (fetch_valid_i) begin
          hw_d    = fetch_rdata_i[31:16];
          state_d = MISALIGNED;
        end
      end

      default: begin
        state_d = ALIGNED;
      end
    endcase

    if (branch_i) begin
      instr_valid = 1'b0;
      fetch_ready = 1'b0;
      hw_d        = hw_q;
      pc_d        = {branch_addr_i[31:1], 1'b0};
      state_d     = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALIGNED;
      hw_q    <= 16'h0;
      pc_q    <= {boot_addr_i[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      hw_q    <= hw_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_ready_o         = fetch_ready;
  assign instr_valid_o         = instr_valid;
  assign instr_aligned_o       = instr;
  assign instr_is_compressed_o = !is_full_len(instr[1:0]);
  assign pc_o                  = pc_q;

endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// Directed self-checking bench for cv32e40p_fetch_aligner.
module tb_cv32e40p_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_aligned_o;
  logic        instr_is_compressed_o;
  logic [31:0] pc_o;
  logic        id_ready_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40p_fetch_aligner dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .boot_addr_i          (boot_addr_i),
    .fetch_valid_i        (fetch_valid_i),
    .fetch_rdata_i        (fetch_rdata_i),
    .fetch_ready_o        (fetch_ready_o),
    .instr_valid_o        (instr_valid_o),
    .instr_aligned_o      (instr_aligned_o),
    .instr_is_compressed_o(instr_is_compressed_o),
    .pc_o                 (pc_o),
    .id_ready_i           (id_ready_i),
    .branch_i             (branch_i),
    .branch_addr_i        (branch_addr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy,
                       input logic br, input logic [31:0] ba);
    fetch_valid_i = v;
    fetch_rdata_i = d;
    id_ready_i    = rdy;
    branch_i      = br;
    branch_addr_i = ba;
    #1;
  endtask

  task automatic expect_ctl(input string tag, input logic v, input logic rdy, input logic [31:0] pc);
    check({tag, "_valid"}, {31'h0, instr_valid_o}, {31'h0, v});
    check({tag, "_ready"}, {31'h0, fetch_ready_o}, {31'h0, rdy});
    check({tag, "_pc"}, pc_o, pc);
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ins, input logic cmp);
    check({tag, "_instr"}, instr_aligned_o, ins);
    check({tag, "_cmp"}, {31'h0, instr_is_compressed_o}, {31'h0, cmp});
  endtask

  initial begin
    rst_n       = 1'b0;
    boot_addr_i = 32'h0000_0083;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    expect_ctl("reset", 1'b0, 1'b0, 32'h80);

    // Aligned 32-bit stream
    rst_n = 1'b1;
    drive(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
    expect_ctl("a32_0", 1'b1, 1'b1, 32'h80);
    expect_instr("a32_0", 32'h0050_0093, 1'b0);
    step();
    drive(1'b1, 32'h0010_0113, 1'b1, 1'b0, 32'h0);
    expect_ctl("a32_1", 1'b1, 1'b1, 32'h84);
    expect_instr("a32_1", 32'h0010_0113, 1'b0);
    step();
    check("a32_pc_after", pc_o, 32'h88);

    // Branch back to 0x80 with a valid word present: handshake void
    drive(1'b1, 32'h4505_0505, 1'b1, 1'b1, 32'h0000_0080);
    expect_ctl("br80", 1'b0, 1'b0, 32'h88);
    step();

    // Compressed pair
    drive(1'b1, 32'h4505_0505, 1'b1, 1'b0, 32'h0);
    expect_ctl("cp_0", 1'b1, 1'b1, 32'h80);
    expect_instr("cp_0", 32'h0000_0505, 1'b1);
    step();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    expect_ctl("cp_1", 1'b1, 1'b0, 32'h82);
    expect_instr("cp_1", 32'h0000_4505, 1'b1);
    step();
    expect_ctl("cp_2", 1'b1, 1'b1, 32'h84);
    expect_instr("cp_2", 32'hDEAD_BEEF, 1'b0);

    // Redirect to 0x80 for the straddling case
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0081);
    expect_ctl("br80b", 1'b0, 1'b0, 32'h84);
    step();

    // Straddling 32-bit
    drive(1'b1, 32'h0093_4505, 1'b1, 1'b0, 32'h0);
    expect_ctl("st_0", 1'b1, 1'b1, 32'h80);
    expect_instr("st_0", 32'h0000_4505, 1'b1);
    step();
    drive(1'b1, 32'hABCD_0050, 1'b1, 1'b0, 32'h0);
    expect_ctl("st_1", 1'b1, 1'b1, 32'h82);
    expect_instr("st_1", 32'h0050_0093, 1'b0);
    step();
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    expect_ctl("st_res", 1'b1, 1'b0, 32'h86);
    expect_instr("st_res", 32'h0000_ABCD, 1'b1);
    step();
    expect_ctl("st_stall", 1'b1, 1'b0, 32'h86);
    expect_instr("st_stall", 32'h0000_ABCD, 1'b1);

    // Branch while a valid instruction stalls (id_ready_i=0)
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0200);
    expect_ctl("br_stall", 1'b0, 1'b0, 32'h86);
    step();
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    expect_ctl("hold200", 1'b1, 1'b0, 32'h200);
    expect_instr("hold200", 32'h0050_0093, 1'b0);
    step();
    check("hold200_pc", pc_o, 32'h200);

    // Branch with id_ready_i=1 in the same cycle, misaligned target
    drive(1'b1, 32'h0050_0093, 1'b1, 1'b1, 32'h0000_0102);
    expect_ctl("br_rdy", 1'b0, 1'b0, 32'h200);
    step();
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    expect_ctl("bmis_bubble", 1'b0, 1'b1, 32'h102);
    step();
    drive(1'b1, 32'h0000_1111, 1'b1, 1'b0, 32'h0);
    expect_ctl("bmis_0", 1'b1, 1'b0, 32'h102);
    expect_instr("bmis_0", 32'h0000_1234, 1'b1);
    step();
    expect_ctl("bmis_1", 1'b1, 1'b1, 32'h104);
    expect_instr("bmis_1", 32'h0000_1111, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_ctl("bmis_2", 1'b1, 1'b0, 32'h106);
    expect_instr("bmis_2", 32'h0000_0000, 1'b1);

    // Reset while a residue is held discards it
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h0);
    expect_ctl("rst_mid", 1'b1, 1'b0, 32'h80);
    expect_instr("rst_mid", 32'h0010_0113, 1'b0);

    // PC wraps past the top of the address space
    drive(1'b1, 32'h0010_0113, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 32'h0010_0113, 1'b1, 1'b0, 32'h0);
    expect_ctl("wrap_0", 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_ctl("wrap_1", 1'b0, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
